// File: rtl/scan_chain_mc.sv
// Multi-chain scan wrapper around a W-bit multiply/add core.
// Owns the 2W-bit operand/result register, a saturating shift counter and a sticky short-load flag.
module scan_chain_mc #(
  parameter int W      = 4,
  parameter int CHAINS = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [CHAINS-1:0] scan_in,
  input  logic              scan_en,
  input  logic              cap_en,
  input  logic              cap_op,
  output logic [CHAINS-1:0] scan_out,
  output logic              load_done,
  output logic              load_err
);

  localparam int R  = 2 * W;
  localparam int L  = R / CHAINS;
  localparam int CW = $clog2(L + 1);
  localparam logic [CW-1:0] L_CNT = CW'(L);

  logic [R-1:0]  r;
  logic [R-1:0]  r_sh;
  logic [R-1:0]  shifted;
  logic [R-1:0]  captured;
  logic [R-1:0]  a_ext;
  logic [R-1:0]  b_ext;
  logic [CW-1:0] cnt;

  assign a_ext = {{W{1'b0}}, r[R-1:W]};
  assign b_ext = {{W{1'b0}}, r[W-1:0]};

  // Sum needs only W+1 bits, the product the full 2W; both zero-extend into r.
  always_comb begin
    captured = cap_op ? (a_ext + b_ext) : (a_ext * b_ext);
  end

  // Whole-register right shift, then each segment's top bit is replaced by its chain input.
  always_comb begin
    r_sh    = r >> 1;
    shifted = r_sh;
    for (int i = 0; i < R; i++) begin
      if ((i % L) == (L - 1)) shifted[i] = scan_in[i / L];
    end
  end

  always_comb begin
    scan_out = '0;
    for (int c = 0; c < CHAINS; c++) begin
      scan_out[c] = r[c * L];
    end
  end

  assign load_done = (cnt == L_CNT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r        <= '0;
      cnt      <= '0;
      load_err <= 1'b0;
    end else if (scan_en) begin
      r <= shifted;
      if (cnt != L_CNT) cnt <= cnt + CW'(1);
    end else if (cap_en) begin
      r   <= captured;
      cnt <= '0;
      // A capture on a partial load still executes; it is only flagged.
      if (cnt != L_CNT) load_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_scan_chain_mc.sv
// Bench for scan_chain_mc: one single-chain (L=8) and one two-chain (L=4) instance,
// directed steps followed by random traffic checked against an arithmetic reference model.
module tb_scan_chain_mc;

  localparam int W = 4;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] se    = '0;
  logic [1:0] ce    = '0;
  logic [1:0] op    = '0;
  logic [0:0] si1   = '0;
  logic [1:0] si2   = '0;
  logic [0:0] so1;
  logic [1:0] so2;
  logic [1:0] ld;
  logic [1:0] le;

  int n_pass  = 0;
  int n_total = 0;

  // Reference state per instance: register value, shift count, sticky error.
  int m_v[2];
  int m_cnt[2];
  int m_err[2];

  scan_chain_mc #(.W(W), .CHAINS(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .scan_in(si1), .scan_en(se[0]), .cap_en(ce[0]),
    .cap_op(op[0]), .scan_out(so1), .load_done(ld[0]), .load_err(le[0])
  );

  scan_chain_mc #(.W(W), .CHAINS(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .scan_in(si2), .scan_en(se[1]), .cap_en(ce[1]),
    .cap_op(op[1]), .scan_out(so2), .load_done(ld[1]), .load_err(le[1])
  );

  always #5 clk = ~clk;

  function automatic int n_chains(int d);
    return (d == 0) ? 1 : 2;
  endfunction

  function automatic int seg_len(int d);
    return (2 * W) / n_chains(d);
  endfunction

  function automatic int m_shift(int d, int v, int si);
    int l   = seg_len(d);
    int res = 0;
    for (int c = 0; c < n_chains(d); c++) begin
      int seg = (v >> (c * l)) % (1 << l);
      seg = seg / 2 + ((si >> c) & 1) * (1 << (l - 1));
      res = res + (seg << (c * l));
    end
    return res;
  endfunction

  function automatic int m_capture(int v, int cop);
    int a = v / (1 << W);
    int b = v % (1 << W);
    return cop ? (a + b) : ((a * b) % (1 << (2 * W)));
  endfunction

  function automatic int exp_so(int d);
    int res = 0;
    for (int c = 0; c < n_chains(d); c++) begin
      res = res + (((m_v[d] >> (c * seg_len(d))) & 1) << c);
    end
    return res;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_v[d] = 0; m_cnt[d] = 0; m_err[d] = 0;
    end
  endtask

  task automatic model_edge();
    for (int d = 0; d < 2; d++) begin
      int si = (d == 0) ? int'(si1) : int'(si2);
      if (se[d]) begin
        m_v[d] = m_shift(d, m_v[d], si);
        if (m_cnt[d] < seg_len(d)) m_cnt[d]++;
      end else if (ce[d]) begin
        if (m_cnt[d] != seg_len(d)) m_err[d] = 1;
        m_v[d]   = m_capture(m_v[d], int'(op[d]));
        m_cnt[d] = 0;
      end
    end
  endtask

  task automatic chk(string tag, int obs, int exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic check_all();
    chk("d1_scan_out",  int'(so1),   exp_so(0));
    chk("d1_load_done", int'(ld[0]), int'(m_cnt[0] == seg_len(0)));
    chk("d1_load_err",  int'(le[0]), m_err[0]);
    chk("d2_scan_out",  int'(so2),   exp_so(1));
    chk("d2_load_done", int'(ld[1]), int'(m_cnt[1] == seg_len(1)));
    chk("d2_load_err",  int'(le[1]), m_err[1]);
  endtask

  // One active edge: model follows the edge, outputs checked 1 time unit later, return at negedge.
  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
    @(negedge clk);
  endtask

  task automatic mid_cycle_reset(string tag);
    #1 rst_n = 1'b0;
    #1;
    model_reset();
    chk({tag, "_so1"}, int'(so1), 0);
    chk({tag, "_so2"}, int'(so2), 0);
    chk({tag, "_done"}, int'(ld), 0);
    chk({tag, "_err"}, int'(le), 0);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    int load_seq[8] = '{1, 0, 1, 0, 0, 1, 0, 1};
    int mul_out[8]  = '{0, 1, 0, 0, 1, 1, 0, 0};
    int add_out[8]  = '{1, 1, 1, 1, 0, 0, 0, 0};
    int mc_hi[4]    = '{1, 0, 1, 0};
    int mc_lo[4]    = '{0, 1, 0, 1};

    // Reset state
    model_reset();
    @(negedge clk);
    @(negedge clk);
    check_all();
    chk("reset_done", int'(ld), 0);
    rst_n = 1'b1;

    // Single-chain load of a=A, b=5
    for (int i = 0; i < 8; i++) begin
      se[0] = 1'b1; si1 = load_seq[i][0:0];
      tick();
    end
    chk("load_done_after_8", int'(ld[0]), 1);

    // Multiply capture and unload
    se[0] = 1'b0; ce[0] = 1'b1; op[0] = 1'b0;
    tick();
    chk("mul_load_done", int'(ld[0]), 0);
    chk("mul_load_err", int'(le[0]), 0);
    chk("mul_out_0", int'(so1), mul_out[0]);
    ce[0] = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      se[0] = 1'b1; si1 = 1'b0;
      tick();
      if (i < 8) chk($sformatf("mul_out_%0d", i), int'(so1), mul_out[i]);
    end
    chk("unload_done", int'(ld[0]), 1);

    // Reload and add capture
    for (int i = 0; i < 8; i++) begin
      si1 = load_seq[i][0:0];
      tick();
    end
    se[0] = 1'b0; ce[0] = 1'b1; op[0] = 1'b1;
    tick();
    chk("add_out_0", int'(so1), add_out[0]);
    ce[0] = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      se[0] = 1'b1; si1 = 1'($urandom_range(0, 1));
      tick();
      if (i < 8) chk($sformatf("add_out_%0d", i), int'(so1), add_out[i]);
    end

    // Short load, hold, flagged capture, then the flag persists
    se[0] = 1'b0; ce[0] = 1'b1; op[0] = 1'b0;
    tick();
    for (int i = 0; i < 3; i++) begin
      se[0] = 1'b1; ce[0] = 1'b0; si1 = 1'($urandom_range(0, 1));
      tick();
    end
    se[0] = 1'b0;
    tick();
    tick();
    chk("hold_not_done", int'(ld[0]), 0);
    ce[0] = 1'b1;
    tick();
    chk("short_load_err", int'(le[0]), 1);
    ce[0] = 1'b0;
    for (int i = 0; i < 8; i++) begin
      se[0] = 1'b1; si1 = load_seq[i][0:0];
      tick();
    end
    se[0] = 1'b0; ce[0] = 1'b1;
    tick();
    chk("err_sticky", int'(le[0]), 1);
    ce[0] = 1'b0;

    // Two-chain load a=5, b=A, multiply
    for (int i = 0; i < 4; i++) begin
      se[1] = 1'b1; si2 = {mc_hi[i][0], mc_lo[i][0]};
      tick();
    end
    chk("mc_load_done", int'(ld[1]), 1);
    chk("mc_so_loaded", int'(so2), 2);
    se[1] = 1'b0; ce[1] = 1'b1; op[1] = 1'b0;
    tick();
    chk("mc_cap_so", int'(so2), 2);
    chk("mc_cap_err", int'(le[1]), 0);
    ce[1] = 1'b0; se[1] = 1'b1; si2 = 2'b00;
    tick();
    chk("mc_shift1_so", int'(so2), 3);
    se[1] = 1'b0;

    // Asynchronous reset after 5 shifts
    for (int i = 0; i < 5; i++) begin
      se[0] = 1'b1; si1 = 1'($urandom_range(0, 1));
      tick();
    end
    mid_cycle_reset("async_rst");
    for (int i = 0; i < 8; i++) begin
      si1 = load_seq[i][0:0];
      tick();
    end
    chk("post_rst_done", int'(ld[0]), 1);
    chk("post_rst_err", int'(le[0]), 0);

    // Random traffic on both instances
    for (int n = 0; n < 400; n++) begin
      for (int d = 0; d < 2; d++) begin
        int mode = $urandom_range(0, 9);
        se[d] = (mode < 7);
        ce[d] = (mode >= 7) && (mode < 9);
        op[d] = 1'($urandom_range(0, 1));
      end
      si1 = 1'($urandom_range(0, 1));
      si2 = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 59) == 0) mid_cycle_reset("rand_rst");
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
